// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcodes, FSM encoding and settle counter width for the ALU arbiter
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Overflow is only meaningful for the arithmetic opcodes.
  function automatic logic masked_overflow(input logic [2:0] op, input logic ovf);
    return ovf & ((op == OP_ADD) | (op == OP_SUB));
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-way round-robin grant with registered priority pointer
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       rr_ptr
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  // After a grant, priority passes to the other requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= grant[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one slow ripple-carry ALU between two requesters
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_overflow,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_overflow,
  output logic [2:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               owner;
  logic [WIDTH-1:0]   result;
  logic               overflow;
  logic [1:0]         grant;
  logic               accept;
  logic               rr_ptr_unused;

  alu_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .enable (state == ST_IDLE),
    .accept (accept),
    .grant  (grant),
    .rr_ptr (rr_ptr_unused)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (cnt == '0) state_nxt = ST_RESPOND;
      ST_RESPOND: if (owner ? rsp1_ready : rsp0_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Operands stay on the ALU pins through SETTLE and are kept after completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      owner         <= 1'b0;
      alu_operation <= OP_ADD;
      alu_a         <= '0;
      alu_b         <= '0;
      result        <= '0;
      overflow      <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        owner         <= grant[1];
        alu_operation <= grant[1] ? req1_op : req0_op;
        alu_a         <= grant[1] ? req1_a : req0_a;
        alu_b         <= grant[1] ? req1_b : req0_b;
        cnt           <= CNT_W'(SETTLE_CYCLES - 1);
      end
    end else if (state == ST_SETTLE) begin
      if (cnt == '0) begin
        result   <= alu_out;
        overflow <= masked_overflow(alu_operation, alu_overflow);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign rsp0_valid    = (state == ST_RESPOND) & ~owner;
  assign rsp1_valid    = (state == ST_RESPOND) & owner;
  assign rsp0_result   = result;
  assign rsp1_result   = result;
  assign rsp0_overflow = overflow;
  assign rsp1_overflow = overflow;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter with a behavioural ALU model
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_overflow;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b, rsp0_result;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_overflow;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b, rsp1_result;
  logic [2:0]       alu_operation;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_overflow, busy;
  logic             force_ovf;
  logic             model_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_overflow(rsp0_overflow),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_overflow(rsp1_overflow),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .busy(busy)
  );

  // Behavioural stand-in for the external ALU; force_ovf turns it into the overflow stub.
  always_comb begin
    alu_out   = '0;
    model_ovf = 1'b0;
    case (alu_operation)
      3'd0: begin
        alu_out   = alu_a + alu_b;
        model_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      3'd1: begin
        alu_out   = alu_a - alu_b;
        model_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      3'd2: alu_out = alu_a ^ alu_b;
      3'd3: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = ~(alu_a & alu_b);
      3'd6: alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a | alu_b;
    endcase
    alu_overflow = model_ovf | force_ovf;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Presents one command and waits (bounded) for the accept edge; waited=-1 on timeout.
  task automatic send(input int p, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, output int waited);
    waited = -1;
    if (p == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((p == 0) ? req0_ready : req1_ready) begin
        waited = i;
        tick();
        break;
      end
      tick();
    end
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // Waits for the response on port p, samples it, then acknowledges it.
  task automatic recv(input int p, output logic [31:0] res, output logic ovf,
                      output logic other_valid, output int lat);
    lat = -1; res = 'x; ovf = 1'bx; other_valid = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((p == 0) ? rsp0_valid : rsp1_valid) begin
        lat = i;
        res = (p == 0) ? rsp0_result : rsp1_result;
        ovf = (p == 0) ? rsp0_overflow : rsp1_overflow;
        other_valid = (p == 0) ? rsp1_valid : rsp0_valid;
        break;
      end
    end
    if (p == 0) rsp0_ready = 1; else rsp1_ready = 1;
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_handshake got=%b want=0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}); end
    total++; if ({alu_operation, alu_a, alu_b} !== '0) begin
      bad++; $display("FAIL reset_alu_pins got op=%0d a=%h b=%h want 0", alu_operation, alu_a, alu_b); end
    total++; if ({rsp0_result, rsp0_overflow} !== '0) begin
      bad++; $display("FAIL reset_result got=%h/%b want 0/0", rsp0_result, rsp0_overflow); end
  endtask

  task automatic test_add();
    int w, lat; logic [31:0] res; logic ovf, oth;
    send(0, 3'd0, 32'd5, 32'd7, w);
    total++; if (w !== 0) begin bad++; $display("FAIL add_ready_wait got=%0d want=0", w); end
    recv(0, res, ovf, oth, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
    total++; if (res !== 32'd12) begin bad++; $display("FAIL add_result got=%h want=0000000c", res); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL add_overflow got=%b want=0", ovf); end
    total++; if (oth !== 1'b0) begin bad++; $display("FAIL add_rsp1_valid got=%b want=0", oth); end
    total++; if (busy !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      bad++; $display("FAIL add_after busy=%b a=%h b=%h want 0/5/7", busy, alu_a, alu_b); end
  endtask

  task automatic test_sub_overflow();
    int w, lat; logic [31:0] res; logic ovf, oth;
    send(1, 3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, w);
    total++; if (w !== 0) begin bad++; $display("FAIL sub_ready_wait got=%0d want=0", w); end
    recv(1, res, ovf, oth, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency got=%0d want=4", lat); end
    total++; if (res !== 32'h8000_0000 || ovf !== 1'b1) begin
      bad++; $display("FAIL sub_result got=%h/%b want=80000000/1", res, ovf); end
    total++; if (oth !== 1'b0) begin bad++; $display("FAIL sub_rsp0_valid got=%b want=0", oth); end
  endtask

  task automatic test_round_robin();
    int idx0, idx1, n, exp_port;
    logic [31:0] exp_res;
    do_reset();
    idx0 = 0; idx1 = 0;
    req0_valid = 1; req0_op = 3'd0; req0_a = 32'd1;          req0_b = 32'd3;
    req1_valid = 1; req1_op = 3'd2; req1_a = 32'hFF00_0000; req1_b = 32'h0F0F_0F0F;
    for (int k = 0; k < 8; k++) begin
      exp_port = k % 2;
      exp_res  = (exp_port == 0) ? 32'(idx0 * 10 + 4) : (32'hFF00_0000 + 32'(idx1)) ^ 32'h0F0F_0F0F;
      #1;
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin tick(); n++; end
      total++; if ({req1_ready, req0_ready} !== ((exp_port == 0) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rr_grant k=%0d got=%b want port %0d", k, {req1_ready, req0_ready}, exp_port); end
      tick();
      if (exp_port == 0) begin
        idx0++;
        if (idx0 == 4) req0_valid = 0; else begin req0_a = 32'(idx0 * 10 + 1); end
      end else begin
        idx1++;
        if (idx1 == 4) req1_valid = 0; else begin req1_a = 32'hFF00_0000 + 32'(idx1); end
      end
      n = 0;
      while (!(rsp0_valid | rsp1_valid) && n < 20) begin tick(); n++; end
      total++; if ({rsp1_valid, rsp0_valid} !== ((exp_port == 0) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rr_rsp_port k=%0d got=%b want port %0d", k, {rsp1_valid, rsp0_valid}, exp_port); end
      total++; if (((exp_port == 0) ? rsp0_result : rsp1_result) !== exp_res) begin
        bad++; $display("FAIL rr_rsp_result k=%0d got=%h want=%h", k,
                        (exp_port == 0) ? rsp0_result : rsp1_result, exp_res); end
      if (exp_port == 0) rsp0_ready = 1; else rsp1_ready = 1;
      tick();
      rsp0_ready = 0; rsp1_ready = 0;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_back_pressure();
    int w, lat, n; logic [31:0] res; logic ovf, oth;
    send(0, 3'd0, 32'd1, 32'd2, w);
    req1_valid = 1; req1_op = 3'd1; req1_a = 32'd10; req1_b = 32'd3;
    n = 0;
    while (!rsp0_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d got valid=%b res=%h req1_ready=%b want 1/3/0",
                        i, rsp0_valid, rsp0_result, req1_ready); end
      tick();
    end
    rsp0_ready = 1;
    #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_in_respond got=%b want=0", req1_ready); end
    tick();
    rsp0_ready = 0;
    total++; if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got req1_ready=%b rsp0_valid=%b want 1/0", req1_ready, rsp0_valid); end
    tick();
    req1_valid = 0;
    recv(1, res, ovf, oth, lat);
    total++; if (res !== 32'd7 || lat !== 4) begin bad++; $display("FAIL hold_next got=%h lat=%0d want=7/4", res, lat); end
  endtask

  task automatic test_overflow_mask();
    int w, lat; logic [31:0] res; logic ovf, oth;
    force_ovf = 1;
    send(0, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
    recv(0, res, ovf, oth, lat);
    total++; if (res !== 32'hF000_F000 || ovf !== 1'b0) begin
      bad++; $display("FAIL mask_and got=%h/%b want=f000f000/0", res, ovf); end
    send(1, 3'd0, 32'd1, 32'd1, w);
    recv(1, res, ovf, oth, lat);
    total++; if (res !== 32'd2 || ovf !== 1'b1) begin
      bad++; $display("FAIL mask_add got=%h/%b want=00000002/1", res, ovf); end
    send(0, 3'd6, 32'h0000_FFFF, 32'h00FF_0000, w);
    recv(0, res, ovf, oth, lat);
    total++; if (res !== 32'hFF00_0000 || ovf !== 1'b0) begin
      bad++; $display("FAIL mask_nor got=%h/%b want=ff000000/0", res, ovf); end
    force_ovf = 0;
  endtask

  task automatic test_reset_mid_settle();
    int w, seen, n;
    send(0, 3'd0, 32'd9, 32'd9, w);
    tick();
    #2;
    reset = 1;
    #1;
    total++; if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
      bad++; $display("FAIL async_reset got=%b want=00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid}); end
    tick();
    reset = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp0_valid | rsp1_valid | busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abandoned_rsp got=%0d cycles want=0", seen); end
    req0_valid = 1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1; req1_op = 3'd0; req1_a = 32'd2; req1_b = 32'd2;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL post_reset_grant got=%b want=01", {req1_ready, req0_ready}); end
    tick();
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (!rsp0_valid && n < 20) begin tick(); n++; end
    total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2) begin
      bad++; $display("FAIL post_reset_rsp got=%b/%h want=1/00000002", rsp0_valid, rsp0_result); end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
  endtask

  initial begin
    reset = 1; force_ovf = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; rsp0_ready = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; rsp1_ready = 0;
    test_reset();
    test_add();
    test_sub_overflow();
    test_round_robin();
    test_back_pressure();
    test_overflow_mask();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 32-bit gate-level ALU instance between two requesters. Round-robin arbitration, valid/ready request and response handshakes. Operands are registered and held stable on the ALU inputs for a programmable settle window, because the structural ALU has long ripple-carry gate delays. The block then captures the result and overflow and returns them to the granted requester. It sits between the two client blocks and a single external `alu` instance.

Parameters:
WIDTH, 32, operand/result width (must match the ALU).
SETTLE_CYCLES, 4, clock cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has a command.
req0_ready  out  1  requester 0 command accepted this cycle.
req0_op  in  3  ALU operation code.
req0_a  in  WIDTH  operand A.
req0_b  in  WIDTH  operand B.
rsp0_valid  out  1  result for requester 0 available.
rsp0_ready  in  1  requester 0 takes the result.
rsp0_result  out  WIDTH  result.
rsp0_overflow  out  1  overflow flag.
req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_result, rsp1_overflow: same as above for requester 1.
alu_operation  out  3  to ALU operation input.
alu_a  out  WIDTH  to ALU operand A.
alu_b  out  WIDTH  to ALU operand B.
alu_out  in  WIDTH  from ALU result.
alu_overflow  in  1  from ALU overflow.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE, rr pointer = 0, settle counter = 0, owner = 0.
  - alu_operation = 0 (ADD), alu_a = alu_b = 0.
  - All result/flag registers = 0; every rsp*_valid and req*_ready = 0.
- Reset mid-transaction abandons the command. No response is issued.
- FSM states: IDLE, SETTLE, RESPOND.
- IDLE:
  - reqN_ready is combinational, asserted only for the granted requester and only in IDLE.
  - Grant rule: if exactly one valid, grant it. If both valid, grant the rr pointer holder.
  - Acceptance (valid & ready at the edge) does all of the following:
    - registers op/a/b onto the alu_* outputs and owner = granted index;
    - sets rr pointer to the other requester;
    - loads counter = SETTLE_CYCLES-1 and moves to SETTLE.
- SETTLE:
  - alu_* outputs held constant.
  - Counter decrements each cycle.
  - At counter==0: capture alu_out into the result register and masked overflow into the flag register, then move to RESPOND.
- RESPOND:
  - rsp<owner>_valid = 1; the other rsp valid stays 0.
  - result/overflow held stable until rsp<owner>_ready=1 at an edge, then go to IDLE.
  - No new request is readied while in RESPOND.
- Latency: rsp valid is first seen SETTLE_CYCLES cycles after the accept edge. Minimum issue interval is SETTLE_CYCLES+2 cycles.
- Overflow mask: rsp overflow = alu_overflow & (op==ADD | op==SUB). It is 0 for every other opcode.
- rsp*_result/overflow outputs show the captured registers at all times. Only the valid bit is owner-qualified.
- alu_* outputs retain the last command after completion; they do not return to 0.
- Requester protocol: valid and payload must stay stable until ready. A valid dropped without ready is ignored.
- All 8 opcodes are legal; the op is passed through unmodified.
- Simultaneous rsp ready and new req valid in RESPOND: the response completes, and the request is readied in the following IDLE cycle.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode constants ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7;
  - FSM state encoding (2 bits);
  - SETTLE counter width (4).
- One sub-module, alu_rr_arbiter:
  - inputs: two valids, enable (state==IDLE), accept pulse;
  - outputs: one-hot grant and the registered rr pointer.

Test Plan:
- Reset, then req0 ADD a=5 b=7, SETTLE_CYCLES=4, real alu instance -> req0_ready the same cycle; rsp0_valid rises 4 cycles after accept; result=12, overflow=0, rsp1_valid=0.
- req1 SUB a=0x7FFFFFFF b=0xFFFFFFFF -> rsp1_result=0x80000000, rsp1_overflow=1.
- Both valid continuously from reset, 4 commands each -> grants alternate 0,1,0,1…; each response is returned to the correct port.
- req0 in RESPOND with rsp0_ready held low 5 cycles while req1 valid -> rsp0_valid/result stable, req1_ready=0 throughout. rsp0_ready=1, then req1_ready=1 on the next cycle.
- Stub ALU forcing alu_overflow=1, op AND a=0xF0F0F0F0 b=0xFF00FF00 -> result 0xF000F000 passed through, rsp overflow=0.
- Reset asserted mid-SETTLE (counter=2) -> busy, ready and valids all 0 immediately (asynchronous); no response after release; next dual request is granted to req0.
